icache_fetch_unit: RTL

- Direct-mapped instruction cache between the instruction fetcher and the memory controller.
- Serves 32-bit instruction reads by PC.
- On a miss, requests a whole block from the memory controller, which returns it one byte per cycle. The cache assembles the bytes, installs the line, then answers the fetcher.
- Mispredict flush suppresses stale responses without aborting an in-flight memory burst.

---
 rtl/icache_fetch_unit_if.sv | 26 ++
 rtl/icache_fetch_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/icache_fetch_unit_if.sv
// Fetcher- and memory-side signals of the instruction cache.
// The cache connects through the slave modport. The environment (the
// fetcher plus the memory controller) connects through the master modport.
interface icache_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic                  if_flush;
  logic                  inst_valid;
  logic [31:0]           inst_out;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_byte_valid;
  logic [7:0]            mem_byte;

  modport slave (
    input  if_req, if_pc, if_flush, mem_byte_valid, mem_byte,
    output inst_valid, inst_out, mem_req, mem_addr
  );

  modport master (
    output if_req, if_pc, if_flush, mem_byte_valid, mem_byte,
    input  inst_valid, inst_out, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_fetch_unit.sv
// Direct-mapped instruction cache. A hit answers one cycle after the request.
// A miss refills the whole block one byte per cycle, installs the line, and
// then answers. A flush only cancels the response. An in-flight burst always
// completes and is still installed.
module icache_fetch_unit #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  icache_fetch_unit_if.slave bus
);
  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int BYTES     = 1 << OFFSET_WIDTH;
  localparam int LINE_BITS = 8 * BYTES;
  localparam int TAG_W     = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WORD_W    = OFFSET_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFILL  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                   state_q;
  logic [LINES-1:0]         valid_q;
  logic [TAG_W-1:0]         tag_q  [LINES];
  logic [LINE_BITS-1:0]     data_q [LINES];
  logic [LINE_BITS-1:0]     buf_q;
  logic [OFFSET_WIDTH-1:0]  cnt_q;
  logic [TAG_W-1:0]         lat_tag_q;
  logic [INDEX_WIDTH-1:0]   lat_idx_q;
  logic [WORD_W-1:0]        lat_word_q;
  logic                     cancel_q;
  logic                     inst_valid_q;
  logic [31:0]              inst_out_q;
  logic                     mem_req_q;
  logic [ADDR_WIDTH-1:0]    mem_addr_q;

  logic [TAG_W-1:0]         req_tag_s;
  logic [INDEX_WIDTH-1:0]   req_idx_s;
  logic [WORD_W-1:0]        req_word_s;
  logic                     hit_s;

  // Split the incoming PC into tag, index and word, then compare against the indexed line.
  always_comb begin
    req_tag_s  = bus.if_pc[ADDR_WIDTH-1:OFFSET_WIDTH+INDEX_WIDTH];
    req_idx_s  = bus.if_pc[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH];
    req_word_s = bus.if_pc[OFFSET_WIDTH-1:2];
    hit_s      = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);
  end

  // Control FSM, line storage and registered outputs. Everything freezes while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      valid_q      <= {LINES{1'b0}};
      buf_q        <= {LINE_BITS{1'b0}};
      cnt_q        <= {OFFSET_WIDTH{1'b0}};
      lat_tag_q    <= {TAG_W{1'b0}};
      lat_idx_q    <= {INDEX_WIDTH{1'b0}};
      lat_word_q   <= {WORD_W{1'b0}};
      cancel_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= 32'h0000_0000;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= {ADDR_WIDTH{1'b0}};
    end else if (!rdy_in) begin
      // A response pulse must not survive a stall and then reappear later.
      inst_valid_q <= 1'b0;
    end else begin
      inst_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.if_req && !bus.if_flush) begin
            if (hit_s) begin
              inst_valid_q <= 1'b1;
              inst_out_q   <= data_q[req_idx_s][{req_word_s, 5'b00000} +: 32];
            end else begin
              lat_tag_q  <= req_tag_s;
              lat_idx_q  <= req_idx_s;
              lat_word_q <= req_word_s;
              cancel_q   <= 1'b0;
              cnt_q      <= {OFFSET_WIDTH{1'b0}};
              mem_req_q  <= 1'b1;
              mem_addr_q <= {req_tag_s, req_idx_s, {OFFSET_WIDTH{1'b0}}};
              state_q    <= REFILL;
            end
          end
        end
        REFILL: begin
          if (bus.if_flush) begin
            cancel_q <= 1'b1;
          end
          if (bus.mem_byte_valid) begin
            buf_q[{cnt_q, 3'b000} +: 8] <= bus.mem_byte;
            cnt_q <= cnt_q + {{(OFFSET_WIDTH-1){1'b0}}, 1'b1};
            if (cnt_q == {OFFSET_WIDTH{1'b1}}) begin
              // The last byte bypasses the buffer so the line is installed in this cycle.
              data_q[lat_idx_q]  <= {bus.mem_byte, buf_q[LINE_BITS-9:0]};
              tag_q[lat_idx_q]   <= lat_tag_q;
              valid_q[lat_idx_q] <= 1'b1;
              mem_req_q          <= 1'b0;
              state_q            <= (cancel_q || bus.if_flush) ? IDLE : RESPOND;
            end
          end
        end
        RESPOND: begin
          if (!bus.if_flush) begin
            inst_valid_q <= 1'b1;
            inst_out_q   <= data_q[lat_idx_q][{lat_word_q, 5'b00000} +: 32];
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.inst_valid = inst_valid_q & rdy_in;
  assign bus.inst_out   = inst_out_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
endmodule
